gpio_event_ctrl: RTL and testbench



---
 rtl/gpio_event_pkg.sv | 17 +
 rtl/gpio_event_ctrl_edge.sv | 37 +++
 rtl/gpio_event_ctrl.sv | 139 +++++++++++++
 tb/tb_gpio_event_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/gpio_event_pkg.sv
// gpio_event_pkg: shared register map and types
// for the GPIO edge-event controller.
package gpio_event_pkg;

  localparam int REG_DATA_W = 32;

  typedef logic [2:0] reg_addr_t;

  localparam reg_addr_t REG_LEVEL         = 3'd0;
  localparam reg_addr_t REG_RISE_EN       = 3'd1;
  localparam reg_addr_t REG_FALL_EN       = 3'd2;
  localparam reg_addr_t REG_PENDING       = 3'd3;
  localparam reg_addr_t REG_IRQ_MASK      = 3'd4;
  localparam reg_addr_t REG_EVENT_COUNT   = 3'd5;
  localparam reg_addr_t REG_FIRST_PENDING = 3'd6;

endpackage

// File: rtl/gpio_event_ctrl_edge.sv
// gpio_edge_detect: previous-sample register with a
// one-shot prime cycle after reset, plus rise/fall.
module gpio_edge_detect #(
  parameter int NUM_PINS = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_PINS-1:0] gpio_in,
  output logic [NUM_PINS-1:0] rise,
  output logic [NUM_PINS-1:0] fall
);

  logic [NUM_PINS-1:0] prev;
  logic                armed;

  // Track last sample; first cycle after reset only primes prev.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev  <= '0;
      armed <= 1'b0;
    end else begin
      prev  <= gpio_in;
      armed <= 1'b1;
    end
  end

  // Edges are suppressed until prev holds a real sample.
  always_comb begin
    rise = '0;
    fall = '0;
    if (armed) begin
      rise = gpio_in & ~prev;
      fall = ~gpio_in & prev;
    end
  end

endmodule

// File: rtl/gpio_event_ctrl.sv
// gpio_event_ctrl: latches enabled pin edges into W1C
// pending bits, counts event cycles, drives masked irq.
module gpio_event_ctrl
  import gpio_event_pkg::*;
#(
  parameter int NUM_PINS = 16,
  parameter int COUNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_PINS-1:0]   gpio_in,
  input  logic                  reg_wr_en,
  input  logic                  reg_rd_en,
  input  logic [2:0]            reg_addr,
  input  logic [REG_DATA_W-1:0] reg_wdata,
  output logic [REG_DATA_W-1:0] reg_rdata,
  output logic                  reg_rd_valid,
  output logic                  irq
);

  logic [NUM_PINS-1:0]   rise;
  logic [NUM_PINS-1:0]   fall;
  logic [NUM_PINS-1:0]   rise_en;
  logic [NUM_PINS-1:0]   fall_en;
  logic [NUM_PINS-1:0]   irq_mask;
  logic [NUM_PINS-1:0]   pending;
  logic [NUM_PINS-1:0]   pending_next;
  logic [NUM_PINS-1:0]   w1c_mask;
  logic [NUM_PINS-1:0]   event_vec;
  logic [COUNT_W-1:0]    count;
  logic [COUNT_W-1:0]    count_next;
  logic [4:0]            first_idx;
  logic [REG_DATA_W-1:0] rd_mux;
  logic [NUM_PINS-1:0]   wdata_pins;
  reg_addr_t             addr;
  logic                  any_event;
  logic                  any_pending;
  logic                  wr_rise;
  logic                  wr_fall;
  logic                  wr_pend;
  logic                  wr_mask;
  logic                  wr_count;
  logic                  unused_ok;

  assign addr       = reg_addr_t'(reg_addr);
  assign wdata_pins = reg_wdata[NUM_PINS-1:0];
  assign unused_ok  = &{1'b0, reg_wdata};

  gpio_edge_detect #(
    .NUM_PINS (NUM_PINS)
  ) u_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .gpio_in (gpio_in),
    .rise    (rise),
    .fall    (fall)
  );

  // Write decode and event/pending/counter next-state.
  always_comb begin
    wr_rise    = reg_wr_en && (addr == REG_RISE_EN);
    wr_fall    = reg_wr_en && (addr == REG_FALL_EN);
    wr_pend    = reg_wr_en && (addr == REG_PENDING);
    wr_mask    = reg_wr_en && (addr == REG_IRQ_MASK);
    wr_count   = reg_wr_en && (addr == REG_EVENT_COUNT);
    w1c_mask   = wr_pend ? wdata_pins : '0;
    event_vec  = (rise & rise_en) | (fall & fall_en);
    any_event  = |event_vec;
    pending_next = (pending & ~w1c_mask) | event_vec;
    count_next = count;
    if (wr_count) begin
      count_next = any_event ? COUNT_W'(1) : '0;
    end else if (any_event && (count != '1)) begin
      count_next = count + COUNT_W'(1);
    end
  end

  // Lowest-index pending pin.
  always_comb begin
    first_idx   = '0;
    any_pending = |pending;
    for (int i = NUM_PINS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        first_idx = 5'(i);
      end
    end
  end

  // Read mux over the current (pre-write) state.
  always_comb begin
    rd_mux = '0;
    unique case (addr)
      REG_LEVEL:       rd_mux = 32'(gpio_in);
      REG_RISE_EN:     rd_mux = 32'(rise_en);
      REG_FALL_EN:     rd_mux = 32'(fall_en);
      REG_PENDING:     rd_mux = 32'(pending);
      REG_IRQ_MASK:    rd_mux = 32'(irq_mask);
      REG_EVENT_COUNT: rd_mux = 32'(count);
      REG_FIRST_PENDING: begin
        if (any_pending) begin
          rd_mux     = 32'(first_idx);
          rd_mux[31] = 1'b1;
        end
      end
      default:         rd_mux = '0;
    endcase
  end

  // Configuration, pending, counter and irq state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rise_en  <= '0;
      fall_en  <= '0;
      irq_mask <= '0;
      pending  <= '0;
      count    <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_rise) rise_en  <= wdata_pins;
      if (wr_fall) fall_en  <= wdata_pins;
      if (wr_mask) irq_mask <= wdata_pins;
      pending <= pending_next;
      count   <= count_next;
      irq     <= |(pending & irq_mask);
    end
  end

  // Registered read port, one cycle of latency.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      reg_rdata    <= '0;
      reg_rd_valid <= 1'b0;
    end else begin
      reg_rd_valid <= reg_rd_en;
      reg_rdata    <= reg_rd_en ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_gpio_event_ctrl.sv
// tb_gpio_event_ctrl: directed stimulus with a read
// scoreboard and direct irq/reset checks.
module tb_gpio_event_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] gpio_in;
  logic        reg_wr_en;
  logic        reg_rd_en;
  logic [2:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        reg_rd_valid;
  logic        irq;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  gpio_event_ctrl #(
    .NUM_PINS (16),
    .COUNT_W  (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .gpio_in      (gpio_in),
    .reg_wr_en    (reg_wr_en),
    .reg_rd_en    (reg_rd_en),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_rdata    (reg_rdata),
    .reg_rd_valid (reg_rd_valid),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  function automatic void check(string nm, logic [31:0] act,
                                logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Monitor: pop one expectation per valid read cycle.
  always @(negedge clk) begin
    if (reg_rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rd_unexpected: got valid %h expected none",
                 reg_rdata);
      end else begin
        check(name_q.pop_front(), reg_rdata, exp_q.pop_front());
      end
    end
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    reg_wr_en = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    @(negedge clk);
    reg_wr_en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e,
                    input string nm);
    reg_rd_en = 1'b1;
    reg_addr  = a;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
    reg_rd_en = 1'b0;
  endtask

  task automatic rw(input logic [2:0] a, input logic [31:0] d,
                    input logic [31:0] e, input string nm);
    reg_rd_en = 1'b1;
    reg_wr_en = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
    reg_rd_en = 1'b0;
    reg_wr_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    gpio_in   = 16'h0001;
    reg_wr_en = 1'b0;
    reg_rd_en = 1'b0;
    reg_addr  = '0;
    reg_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_valid", 32'(reg_rd_valid), 32'h0);
    check("rst_rdata", reg_rdata, 32'h0);

    // Pin held high through reset: prime cycle, no event.
    reset_n = 1'b1;
    wr(3'd1, 32'h0001);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("prime_irq", 32'(irq), 32'h0);
    end
    rd(3'd3, 32'h0, "prime_pending");
    rd(3'd5, 32'h0, "prime_count");

    // Rising edges on pins 0 and 2, only pin 2 masked.
    wr(3'd1, 32'h0005);
    wr(3'd4, 32'h0004);
    gpio_in = 16'h0000;
    @(negedge clk);
    gpio_in = 16'h0005;
    @(negedge clk);
    check("irq_edge_k", 32'(irq), 32'h0);
    @(negedge clk);
    check("irq_edge_k1", 32'(irq), 32'h1);
    rd(3'd3, 32'h0005, "rise_pending");
    rd(3'd5, 32'h1, "rise_count");
    rd(3'd6, 32'h8000_0000, "first_pin0");
    rd(3'd0, 32'h0005, "level");

    // Falling edge on pin 4 beats a same-cycle W1C.
    wr(3'd2, 32'h0010);
    gpio_in = 16'h0015;
    @(negedge clk);
    gpio_in = 16'h0005;
    @(negedge clk);
    gpio_in = 16'h0015;
    @(negedge clk);
    gpio_in = 16'h0005;
    wr(3'd3, 32'h0010);
    rd(3'd3, 32'h0015, "set_wins_w1c");
    rd(3'd5, 32'h3, "fall_count");

    // Clearing the only masked bit drops irq a cycle later.
    wr(3'd3, 32'h0004);
    check("irq_w1c_k", 32'(irq), 32'h1);
    @(negedge clk);
    check("irq_w1c_k1", 32'(irq), 32'h0);
    rd(3'd3, 32'h0011, "w1c_pending");
    wr(3'd3, 32'h0001);
    rd(3'd6, 32'h8000_0004, "first_pin4");
    rw(3'd4, 32'h0010, 32'h0004, "rw_old_mask");
    check("irq_mask_k", 32'(irq), 32'h0);
    @(negedge clk);
    check("irq_mask_k1", 32'(irq), 32'h1);

    // Counter saturation at 4 bits, then clear plus event.
    wr(3'd2, 32'h0011);
    wr(3'd5, 32'h0);
    for (int i = 0; i < 20; i++) begin
      gpio_in = gpio_in ^ 16'h0001;
      @(negedge clk);
    end
    rd(3'd5, 32'hF, "count_sat");
    gpio_in = 16'h0004;
    wr(3'd5, 32'h0);
    rd(3'd5, 32'h1, "count_clr_ev");
    gpio_in = 16'h0000;
    @(negedge clk);
    gpio_in = 16'h0005;
    @(negedge clk);
    rd(3'd5, 32'h2, "count_multi_pin");
    rd(3'd0, 32'h0005, "level2");
    wr(3'd7, 32'hFFFF_FFFF);
    rd(3'd7, 32'h0, "reserved");
    check("irq_before_rst", 32'(irq), 32'h1);

    // Mid-operation reset.
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_irq", 32'(irq), 32'h0);
    check("midrst_valid", 32'(reg_rd_valid), 32'h0);
    check("midrst_rdata", reg_rdata, 32'h0);
    reset_n = 1'b1;
    rd(3'd3, 32'h0, "post_rst_pending");
    rd(3'd1, 32'h0, "post_rst_rise_en");
    rd(3'd7, 32'h0, "post_rst_reserved");
    repeat (3) @(negedge clk);
    check("post_rst_irq", 32'(irq), 32'h0);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
